// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 stream demux.
// Build option: DEMUX_CNT_EN adds per-output transfer counters.
package demux_pkg;
  localparam int N_OUT = 4;
  typedef logic [1:0] sel_t;
endpackage

// File: rtl/demux_out_slot.sv
// One-entry output buffer of the stream demux.
// Build option: DEMUX_CNT_EN adds a wrapping drain counter.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  logic drain;

  assign drain = out_valid & out_ready;

  // A load wins over a drain: the old beat leaves, the new one lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (drain)
      cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 valid/ready stream demultiplexer.
// Build option: DEMUX_CNT_EN exposes xfer_cnt.
module stream_demux_1_4
  import demux_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid,
  output logic               up_ready,
  input  sel_t               up_sel,
  input  logic [W-1:0]       up_data,
  output logic [N_OUT-1:0]   down_valid,
  input  logic [N_OUT-1:0]   down_ready,
  output logic [N_OUT*W-1:0] down_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0] xfer_cnt
`endif
);

  logic [N_OUT-1:0] load;

  // No path from up_valid to up_ready.
  assign up_ready = ~down_valid[up_sel] | down_ready[up_sel];

  always_comb begin
    load = '0;
    load[up_sel] = up_valid & up_ready;
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    demux_out_slot #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .in_data   (up_data),
      .out_valid (down_valid[i]),
      .out_ready (down_ready[i]),
      .out_data  (down_data[i*W +: W])
`ifdef DEMUX_CNT_EN
      ,
      .cnt       (xfer_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule
